// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b memory access unit: the sequencer state enum
// and the byte-enable type for the default 16-bit memory word.
package lc3b_types;

    // Sequencer states of the load/store engine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_t;

    // Per-lane write enable for the default 16-bit word (two byte lanes)
    typedef logic [1:0] lc3b_mem_be;

    localparam int unsigned LC3B_WORD_WIDTH = 16;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request and memory-port bundle of the memory access unit.
// The slave modport is the unit itself; the master modport is the
// environment around it (control FSM on the request side, memory on the
// response side).
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic                    req_byte;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_byte_enable;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_resp;

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, done, err, rdata,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, done, err, rdata,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering for the memory access unit.
// Store side: replicates the low byte into every lane for byte stores and
// builds the byte enables. Load side: extracts one lane and zero-extends it.
module mem_lane_steer #(
    parameter int DATA_WIDTH = 16,
    localparam int LANES     = DATA_WIDTH / 8,
    localparam int LB        = $clog2(LANES)
) (
    input  logic                  i_st_write,
    input  logic                  i_st_byte,
    input  logic [LB-1:0]         i_st_lane,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic [DATA_WIDTH-1:0] o_st_data,
    output logic [LANES-1:0]      o_st_be,
    input  logic                  i_ld_byte,
    input  logic [LB-1:0]         i_ld_lane,
    input  logic [DATA_WIDTH-1:0] i_ld_data,
    output logic [DATA_WIDTH-1:0] o_ld_data
);

    // Store path: loads and word stores enable every lane, byte stores one
    always_comb begin
        o_st_data = i_st_data;
        o_st_be   = '1;
        if (i_st_write && i_st_byte) begin
            o_st_data          = {LANES{i_st_data[7:0]}};
            o_st_be            = '0;
            o_st_be[i_st_lane] = 1'b1;
        end
    end

    // Load path: byte loads return the addressed lane with zeros above it
    always_comb begin
        o_ld_data = i_ld_data;
        if (i_ld_byte) begin
            o_ld_data      = '0;
            o_ld_data[7:0] = i_ld_data[{i_ld_lane, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Self-sequencing load/store engine for the multicycle LC-3b datapath.
// Accepts one request at a time, drives a handshaked memory port with
// strobes held until mem_resp, and returns zero-extended read data with a
// one-cycle done pulse. Misaligned word accesses finish with err and never
// touch memory.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// sees no mem_resp within TIMEOUT_CYCLES cycles (done with err).
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);

    mau_state_t            r_state;
    mau_state_t            w_next;
    logic                  r_write;
    logic                  r_byte;
    logic [LB-1:0]         r_lane;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LANES-1:0]      r_be;

    logic                  w_accept;
    logic [LB-1:0]         w_lane;
    logic                  w_misaligned;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [LANES-1:0]      w_st_be;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_accept     = bus.req_valid && (r_state == IDLE);
    assign w_lane       = bus.req_addr[LB-1:0];
    assign w_misaligned = !bus.req_byte && (w_lane != '0);

    assign bus.rdata           = r_rdata;
    assign bus.mem_address     = r_address;
    assign bus.mem_wdata       = r_wdata;
    assign bus.mem_byte_enable = r_be;

    // Store steering uses the live request; load steering uses the latched lane
    mem_lane_steer #(.DATA_WIDTH(DATA_WIDTH)) u_steer (
        .i_st_write (bus.req_write),
        .i_st_byte  (bus.req_byte),
        .i_st_lane  (w_lane),
        .i_st_data  (bus.req_wdata),
        .o_st_data  (w_st_data),
        .o_st_be    (w_st_be),
        .i_ld_byte  (r_byte),
        .i_ld_lane  (r_lane),
        .i_ld_data  (bus.mem_rdata),
        .o_ld_data  (w_ld_data)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_to_count;

    assign w_timeout = (r_state == ACCESS) && !bus.mem_resp &&
                       (r_to_count == TW'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles without a response; restarts at every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_count <= '0;
        end else if (w_accept) begin
            r_to_count <= '0;
        end else if (r_state == ACCESS && !bus.mem_resp) begin
            r_to_count <= r_to_count + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset lands in IDLE so the strobes drop at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs, decoded from the current state
    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = w_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_read  = !r_write;
                bus.mem_write = r_write;
                if (bus.mem_resp || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                bus.err  = r_err;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request capture at accept, read data capture on the memory response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_byte    <= 1'b0;
            r_lane    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_address <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else if (w_accept) begin
            r_write   <= bus.req_write;
            r_byte    <= bus.req_byte;
            r_lane    <= w_lane;
            r_err     <= w_misaligned;
            r_address <= {bus.req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            r_wdata   <= w_st_data;
            r_be      <= w_st_be;
        end else if (r_state == ACCESS) begin
            if (bus.mem_resp) begin
                if (!r_write) begin
                    r_rdata <= w_ld_data;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (16-bit word, TIMEOUT_CYCLES = 8).
// The driver knows the per-transaction timeline (accept, N strobe cycles,
// one done cycle) and publishes the expected outputs for every cycle; a
// single compare process checks them on the falling edge. Directed cases
// pin the model with literal values. Timeout cases run only when
// MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_access_unit #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic        checkEn = 1'b0;
    logic        expReady, expDone, expErr, expRead, expWrite, expBusChk;
    logic [15:0] expRdata, expAddr, expWdata;
    logic [1:0]  expBe;
    logic [15:0] modelRdata = 16'h0000;

    int          readHigh  = 0;
    int          writeHigh = 0;
    logic [15:0] seenAddr  = 16'h0;
    logic [15:0] seenWdata = 16'h0;
    logic [1:0]  seenBe    = 2'b00;

    // One comparison: counts it, and reports it when it does not match
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every published expectation on the falling edge
    always @(negedge clk) begin
        if (bus.mem_read)  readHigh++;
        if (bus.mem_write) writeHigh++;
        if (bus.mem_read || bus.mem_write) begin
            seenAddr  = bus.mem_address;
            seenWdata = bus.mem_wdata;
            seenBe    = bus.mem_byte_enable;
        end
        if (checkEn) begin
            checkOutput("req_ready", bus.req_ready, expReady);
            checkOutput("done",      bus.done,      expDone);
            checkOutput("mem_read",  bus.mem_read,  expRead);
            checkOutput("mem_write", bus.mem_write, expWrite);
            checkOutput("rdata",     bus.rdata,     expRdata);
            if (expDone) checkOutput("err", bus.err, expErr);
            if (expBusChk) begin
                checkOutput("mem_address",     bus.mem_address,     expAddr);
                checkOutput("mem_wdata",       bus.mem_wdata,       expWdata);
                checkOutput("mem_byte_enable", bus.mem_byte_enable, expBe);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdleExp();
        expReady  = 1'b1;
        expDone   = 1'b0;
        expErr    = 1'b0;
        expRead   = 1'b0;
        expWrite  = 1'b0;
        expBusChk = 1'b0;
        expRdata  = modelRdata;
    endtask

    // Random mem_resp / mem_rdata outside ACCESS must have no effect
    task automatic randomNoise();
        bus.mem_resp  = 1'($urandom_range(0, 1));
        bus.mem_rdata = 16'($urandom);
    endtask

    // Request fields after accept must have no effect
    task automatic scrambleReq();
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_byte  = 1'($urandom_range(0, 1));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    // One full transaction; memory answers after waitCycles extra cycles
    task automatic applyStimulus(input bit wr, input bit byt, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int waitCycles,
                                 input logic [15:0] memWord);
        int lane     = int'(addr[0]);
        int nAccess  = waitCycles + 1;
        bit timedOut = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (nAccess > TO) begin
            nAccess  = TO;
            timedOut = 1'b1;
        end
`endif
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_byte  = byt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        randomNoise();
        setIdleExp();
        readHigh  = 0;
        writeHigh = 0;
        tick();
        bus.req_valid = 1'b0;
        scrambleReq();
        if (!byt && lane != 0) begin
            expReady = 1'b0;
            expDone  = 1'b1;
            expErr   = 1'b1;
            randomNoise();
            tick();
            setIdleExp();
            return;
        end
        expReady  = 1'b0;
        expRead   = !wr;
        expWrite  = wr;
        expBusChk = 1'b1;
        expAddr   = addr & 16'hFFFE;
        expWdata  = (wr && byt) ? {2{wdata[7:0]}} : wdata;
        expBe     = (wr && byt) ? 2'(1 << lane) : 2'b11;
        for (int i = 0; i < nAccess; i++) begin
            bus.mem_resp  = !timedOut && (i == waitCycles);
            bus.mem_rdata = bus.mem_resp ? memWord : 16'($urandom);
            bus.req_valid = 1'($urandom_range(0, 1));
            scrambleReq();
            tick();
        end
        bus.req_valid = 1'b0;
        if (!wr && !timedOut) begin
            modelRdata = byt ? ((memWord >> (8 * lane)) & 16'h00FF) : memWord;
        end
        expReady  = 1'b0;
        expDone   = 1'b1;
        expErr    = timedOut;
        expRead   = 1'b0;
        expWrite  = 1'b0;
        expBusChk = 1'b0;
        expRdata  = modelRdata;
        randomNoise();
        tick();
        setIdleExp();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'h0;
        #3;
        checkOutput("rst_req_ready", bus.req_ready,       1);
        checkOutput("rst_done",      bus.done,            0);
        checkOutput("rst_err",       bus.err,             0);
        checkOutput("rst_mem_read",  bus.mem_read,        0);
        checkOutput("rst_mem_write", bus.mem_write,       0);
        checkOutput("rst_rdata",     bus.rdata,           0);
        checkOutput("rst_mem_addr",  bus.mem_address,     0);
        checkOutput("rst_mem_wdata", bus.mem_wdata,       0);
        checkOutput("rst_mem_be",    bus.mem_byte_enable, 0);
        tick();
        tick();
        rst = 1'b0;
        setIdleExp();
        checkEn = 1'b1;
        tick();

        // Word load, three wait cycles
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000, 3, 16'hBEEF);
        checkOutput("pin_word_load_read_cycles", readHigh, 4);
        checkOutput("pin_word_load_rdata", bus.rdata, 16'hBEEF);

        // Byte store to the upper lane
        applyStimulus(1'b1, 1'b1, 16'h3001, 16'h12A5, 1, 16'h0000);
        checkOutput("pin_byte_store_addr",  seenAddr,  16'h3000);
        checkOutput("pin_byte_store_wdata", seenWdata, 16'hA5A5);
        checkOutput("pin_byte_store_be",    seenBe,    2'b10);
        checkOutput("pin_byte_store_write_cycles", writeHigh, 2);
        checkOutput("pin_store_keeps_rdata", bus.rdata, 16'hBEEF);

        // Byte loads from each lane
        applyStimulus(1'b0, 1'b1, 16'h3001, 16'h0000, 0, 16'hBEEF);
        checkOutput("pin_byte_load_hi", bus.rdata, 16'h00BE);
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h0000, 2, 16'hBEEF);
        checkOutput("pin_byte_load_lo", bus.rdata, 16'h00EF);

        // Misaligned word load
        applyStimulus(1'b0, 1'b0, 16'h3003, 16'h0000, 0, 16'h1111);
        checkOutput("pin_misaligned_no_read",  readHigh,  0);
        checkOutput("pin_misaligned_no_write", writeHigh, 0);
        checkOutput("pin_misaligned_rdata",    bus.rdata, 16'h00EF);

        // Reset in the middle of an access
        checkEn       = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h4000;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checkOutput("rst_mid_pre_read", bus.mem_read, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_read",  bus.mem_read,  0);
        checkOutput("rst_mid_write", bus.mem_write, 0);
        checkOutput("rst_mid_ready", bus.req_ready, 1);
        checkOutput("rst_mid_done",  bus.done,      0);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_resp = 1'b0;
        rst          = 1'b0;
        modelRdata   = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_mid_after_done",  bus.done,      0);
            checkOutput("rst_mid_after_ready", bus.req_ready, 1);
            checkOutput("rst_mid_after_read",  bus.mem_read,  0);
            checkOutput("rst_mid_after_rdata", bus.rdata,     0);
        end
        tick();
        setIdleExp();
        checkEn = 1'b1;
        tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Memory never answers: abort after TO strobe cycles
        applyStimulus(1'b0, 1'b0, 16'h5000, 16'h0000, 20, 16'h1234);
        checkOutput("pin_timeout_read_cycles", readHigh, TO);
        checkOutput("pin_timeout_rdata", bus.rdata, 16'h0000);
        // Response in the expiry cycle wins
        applyStimulus(1'b0, 1'b0, 16'h5002, 16'h0000, TO - 1, 16'h1234);
        checkOutput("pin_late_resp_read_cycles", readHigh, TO);
        checkOutput("pin_late_resp_rdata", bus.rdata, 16'h1234);
`endif

        // Randomized transactions, some back-to-back
        for (int n = 0; n < 60; n++) begin
            int gap;
            int maxWait;
`ifdef MEM_ACCESS_TIMEOUT_EN
            maxWait = 10;
`else
            maxWait = 5;
`endif
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom),
                          int'($urandom_range(0, maxWait)), 16'($urandom));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                randomNoise();
                tick();
            end
        end

        checkEn = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit that replaces the fixed MAR/MDR pair and byte-modifier muxes of the multicycle LC-3b datapath with a self-sequencing load/store engine. It accepts one request at a time from the control FSM and performs byte-lane steering on both paths. It drives a handshaked memory port (read/write strobes held until `mem_resp`, per-lane byte enables) and returns zero-extended read data with a one-cycle completion pulse. It sits between the datapath ALU/regfile and the cache/memory interface.

## Interface
- `DATA_WIDTH`, 16, memory word width in bits; multiple of 8, at least 16.
- `ADDR_WIDTH`, 16, byte address width.
- `TIMEOUT_CYCLES`, 64, cycles in ACCESS before abort; used only when timeout is compiled in.
- `clk` in 1: the block's only clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: unit idle; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = full word.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data; byte stores use bits [7:0].
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; set for misaligned word or timeout.
- `rdata` out DATA_WIDTH: load result, held until the next accept.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out ADDR_WIDTH: word-aligned address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_byte_enable` out DATA_WIDTH/8: per-lane write enables.
- `mem_rdata` in DATA_WIDTH: memory read data.
- `mem_resp` in 1: memory response.

## Operation
- LANES = DATA_WIDTH/8. LB = $clog2(LANES). Lane = `req_addr[LB-1:0]`.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - `req_ready`=1.
  - On accept, latch the address into MAR, `mem_address` = addr with the low LB bits cleared.
  - Word access with lane≠0: go to DONE with err=1. No memory strobe is issued. `rdata` is unchanged.
  - Otherwise go to ACCESS.
- Byte store:
  - `mem_wdata` = `req_wdata[7:0]` replicated into every lane.
  - `mem_byte_enable` = one-hot of lane.
- Word store: `mem_wdata` = `req_wdata`, all enables set.
- Loads: `mem_byte_enable` = all ones (don't-care to memory).
- ACCESS:
  - `mem_read`/`mem_write` held high continuously until `mem_resp` is sampled high.
  - On `mem_resp`, a load captures `mem_rdata` into the MDR.
  - Next state DONE, strobes low.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `rdata` for a word load = MDR.
  - `rdata` for a byte load = {zeros, MDR lane byte}.
  - `rdata` for a store = previous value.
- `req_valid` while `req_ready`=0 is ignored, not queued.
- `mem_resp` outside ACCESS is ignored.
- Request fields are sampled only at accept; later changes have no effect.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1.
  - `done`=0, `err`=0.
  - `mem_read`=0, `mem_write`=0.
  - `rdata`=0, `mem_address`=0, `mem_wdata`=0, `mem_byte_enable`=0.
- Accept at edge E0: strobes high in cycle E0+1.
- `mem_resp` high in cycle k gives `done` in cycle k+1 and IDLE in cycle k+2.
- Minimum latency: `mem_resp` in the first ACCESS cycle gives `done` 2 cycles after accept. Back-to-back accepts are possible every 3 cycles.
- Misaligned word: `done`/`err` in the cycle after accept.
- `rst` asserted mid-ACCESS drops the strobes immediately (asynchronously). No `done` is produced. A late `mem_resp` is ignored.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN`
  - Defined:
    - A counter clears on entry to ACCESS and increments each ACCESS cycle without `mem_resp`.
    - After TIMEOUT_CYCLES cycles the strobes drop and the unit goes to DONE with err=1. `rdata` is unchanged.
    - `mem_resp` in the same cycle as expiry wins; the access completes normally.
  - Undefined: the unit waits indefinitely and no counter is instantiated.

## Structure
- Package `lc3b_types` gains:
  - `mau_state_t` enum (IDLE, ACCESS, DONE).
  - A `lc3b_mem_be` typedef for the 2-bit enable of the default width.
- One combinational sub-module, `mem_lane_steer` (parametrised on DATA_WIDTH), computes:
  - store data replication and byte enables;
  - load lane extract with zero extension.

## Test plan
- Word load at 0x3000, `mem_resp` after 3 wait cycles, `mem_rdata`=0xBEEF:
  - `mem_read` high exactly 4 cycles;
  - `done` with `rdata`=0xBEEF, err=0.
- Byte store at 0x3001 with data 0x12A5:
  - `mem_address`=0x3000, `mem_wdata`=0xA5A5, `mem_byte_enable`=2'b10, `mem_write` until `mem_resp`.
- Byte load at 0x3001 with `mem_rdata`=0xBEEF:
  - `rdata`=0x00BE.
  - At 0x3000, `rdata`=0x00EF.
- Word load at 0x3003:
  - no strobe;
  - `done`=1, err=1 one cycle after accept;
  - `rdata` keeps its prior value.
- Assert `rst` during ACCESS, then pulse `mem_resp`:
  - strobes low immediately, no `done`, `req_ready`=1.
- With `MEM_ACCESS_TIMEOUT_EN` and TIMEOUT_CYCLES=8, never respond:
  - `mem_read` high 8 cycles, then `done` with err=1.
  - Repeat with `mem_resp` on cycle 8: err=0.
